// File: rtl/rng_pkg.sv
// Shared definitions for the TRNG register bank: register offsets (paddr[7:0]),
// CTRL/STATUS bit positions and the entropy-collection FSM state type.
package rng_pkg;

  localparam logic [7:0] RNG_CTRL_OFS       = 8'h00;
  localparam logic [7:0] RNG_STATUS_OFS     = 8'h04;
  localparam logic [7:0] RNG_SAMPLE_CNT_OFS = 8'h08;
  localparam logic [7:0] RNG_ICR_OFS        = 8'h0C;
  localparam logic [7:0] RNG_EHR0_OFS       = 8'h10;
  localparam logic [7:0] RNG_EHR1_OFS       = 8'h14;
  localparam logic [7:0] RNG_EHR2_OFS       = 8'h18;
  localparam logic [7:0] RNG_EHR3_OFS       = 8'h1C;
  localparam logic [7:0] RNG_EHR4_OFS       = 8'h20;
  localparam logic [7:0] RNG_EHR5_OFS       = 8'h24;

  // CTRL bits
  localparam int unsigned CTRL_RND_EN_BIT = 0;
  localparam int unsigned CTRL_INT_EN_BIT = 1;

  // STATUS bits
  localparam int unsigned STATUS_EHR_VALID_BIT = 0;
  localparam int unsigned STATUS_BUSY_BIT      = 1;
  localparam int unsigned STATUS_IRQ_PEND_BIT  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } rng_state_e;

endpackage

// File: rtl/rng_sampler.sv
// Entropy-collection engine: sample-rate counter, bit counter, EHR shift
// register and the IDLE/COLLECT/FULL state machine.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   rnd_en          CTRL.RND_EN
//   sample_cnt      SAMPLE_CNT register (reload value of the rate counter)
//   rnd_bit_in      synchronised ring-oscillator bit
//   ehr_last_rd     read strobe to the last EHR word (consumes the EHR)
//   ehr             entropy holding register contents
//   ehr_valid       EHR full and not yet consumed
//   busy            FSM is in COLLECT
//   rosc_en         ring-oscillator enable (registered)
//   full_set        one-cycle pulse on the edge that fills the EHR
module rng_sampler
  import rng_pkg::*;
#(
  parameter int unsigned EHR_WIDTH = 192
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rnd_en,
  input  logic [15:0]          sample_cnt,
  input  logic                 rnd_bit_in,
  input  logic                 ehr_last_rd,
  output logic [EHR_WIDTH-1:0] ehr,
  output logic                 ehr_valid,
  output logic                 busy,
  output logic                 rosc_en,
  output logic                 full_set
);

  localparam logic [7:0] LastBit = 8'(EHR_WIDTH - 1);

  rng_state_e  state_q;
  logic [15:0] smp_cnt_q;
  logic [7:0]  bit_cnt_q;
  logic        sample;

  assign sample   = (state_q == COLLECT) && rnd_en && (smp_cnt_q == 16'd0);
  assign full_set = sample && (bit_cnt_q == LastBit);
  assign busy     = (state_q == COLLECT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      smp_cnt_q <= '0;
      bit_cnt_q <= '0;
      ehr       <= '0;
      ehr_valid <= 1'b0;
      rosc_en   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rnd_en) begin
            state_q   <= COLLECT;
            smp_cnt_q <= sample_cnt;
            bit_cnt_q <= '0;
            rosc_en   <= 1'b1;
          end
        end
        COLLECT: begin
          if (!rnd_en) begin
            // Abort: drop the partial collection entirely.
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            ehr       <= '0;
            rosc_en   <= 1'b0;
          end else if (sample) begin
            ehr       <= {ehr[EHR_WIDTH-2:0], rnd_bit_in};
            bit_cnt_q <= bit_cnt_q + 8'd1;
            smp_cnt_q <= sample_cnt;
            if (full_set) begin
              state_q   <= FULL;
              ehr_valid <= 1'b1;
              rosc_en   <= 1'b0;
            end
          end else begin
            smp_cnt_q <= smp_cnt_q - 16'd1;
          end
        end
        FULL: begin
          // EHR stays frozen until software reads the last word.
          if (ehr_last_rd) begin
            ehr       <= '0;
            bit_cnt_q <= '0;
            ehr_valid <= 1'b0;
            if (rnd_en) begin
              state_q   <= COLLECT;
              smp_cnt_q <= sample_cnt;
              rosc_en   <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          rosc_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/rng_ehr_regs.sv
// TRNG register bank on the RNG APB slice: CTRL, STATUS, SAMPLE_CNT, ICR and
// the read-only EHR_DATA words, plus the level interrupt.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   cpu_rng_psel      slice select (setup and access cycles)
//   cpu_rng_pwrite    pwrite & penable (write access cycle only)
//   cpu_rng_paddr     address, [7:0] decoded
//   cpu_rng_pwdata    write data
//   rng_cpu_prdata    combinational read data, 0 when not selected
//   rnd_bit_in        synchronised ring-oscillator bit
//   rosc_en           ring-oscillator enable
//   rng_irq           registered IRQ_PEND & INT_EN
module rng_ehr_regs
  import rng_pkg::*;
#(
  parameter int unsigned EHR_WIDTH      = 192,
  parameter logic [15:0] SAMPLE_CNT_RST = 16'd100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_rng_psel,
  input  logic        cpu_rng_pwrite,
  input  logic [11:0] cpu_rng_paddr,
  input  logic [31:0] cpu_rng_pwdata,
  output logic [31:0] rng_cpu_prdata,
  input  logic        rnd_bit_in,
  output logic        rosc_en,
  output logic        rng_irq
);

  localparam int unsigned NumWords = EHR_WIDTH / 32;
  localparam logic [7:0]  EhrLastOfs = RNG_EHR0_OFS + 8'(4 * (NumWords - 1));

  logic        phase_q;
  logic        rnd_en_q;
  logic        int_en_q;
  logic [15:0] sample_cnt_q;
  logic        irq_pend_q;
  logic        rng_irq_q;

  logic [7:0]  addr;
  logic        wr_stb;
  logic        rd_stb;
  logic        ehr_last_rd;
  logic [7:0]  ehr_ofs;
  logic        ehr_hit;

  logic [EHR_WIDTH-1:0] ehr;
  logic                 ehr_valid;
  logic                 busy;
  logic                 full_set;

  logic [19:0] unused_bits;
  assign unused_bits = {cpu_rng_pwdata[31:16], cpu_rng_paddr[11:8]};

  assign addr   = cpu_rng_paddr[7:0];
  // pwrite already carries penable, so it alone marks the write access cycle.
  assign wr_stb = cpu_rng_psel & cpu_rng_pwrite;
  assign rd_stb = cpu_rng_psel & phase_q & ~cpu_rng_pwrite;
  assign ehr_last_rd = rd_stb && (addr == EhrLastOfs);

  assign ehr_ofs = addr - RNG_EHR0_OFS;
  assign ehr_hit = (addr >= RNG_EHR0_OFS) && (ehr_ofs[7:2] < 6'(NumWords)) &&
                   (ehr_ofs[1:0] == 2'b00);

  assign rng_irq = rng_irq_q;

  rng_sampler #(
    .EHR_WIDTH (EHR_WIDTH)
  ) u_sampler (
    .clk         (clk),
    .rst_n       (rst_n),
    .rnd_en      (rnd_en_q),
    .sample_cnt  (sample_cnt_q),
    .rnd_bit_in  (rnd_bit_in),
    .ehr_last_rd (ehr_last_rd),
    .ehr         (ehr),
    .ehr_valid   (ehr_valid),
    .busy        (busy),
    .rosc_en     (rosc_en),
    .full_set    (full_set)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q      <= 1'b0;
      rnd_en_q     <= 1'b0;
      int_en_q     <= 1'b0;
      sample_cnt_q <= SAMPLE_CNT_RST;
      irq_pend_q   <= 1'b0;
      rng_irq_q    <= 1'b0;
    end else begin
      phase_q <= cpu_rng_psel ? ~phase_q : 1'b0;
      if (wr_stb && (addr == RNG_CTRL_OFS)) begin
        rnd_en_q <= cpu_rng_pwdata[CTRL_RND_EN_BIT];
        int_en_q <= cpu_rng_pwdata[CTRL_INT_EN_BIT];
      end
      if (wr_stb && (addr == RNG_SAMPLE_CNT_OFS)) begin
        sample_cnt_q <= cpu_rng_pwdata[15:0];
      end
      // A new fill beats a simultaneous ICR clear.
      if (full_set) begin
        irq_pend_q <= 1'b1;
      end else if (wr_stb && (addr == RNG_ICR_OFS) && cpu_rng_pwdata[0]) begin
        irq_pend_q <= 1'b0;
      end
      rng_irq_q <= irq_pend_q & int_en_q;
    end
  end

  always_comb begin
    rng_cpu_prdata = '0;
    if (cpu_rng_psel) begin
      case (addr)
        RNG_CTRL_OFS: begin
          rng_cpu_prdata[CTRL_RND_EN_BIT] = rnd_en_q;
          rng_cpu_prdata[CTRL_INT_EN_BIT] = int_en_q;
        end
        RNG_STATUS_OFS: begin
          rng_cpu_prdata[STATUS_EHR_VALID_BIT] = ehr_valid;
          rng_cpu_prdata[STATUS_BUSY_BIT]      = busy;
          rng_cpu_prdata[STATUS_IRQ_PEND_BIT]  = irq_pend_q;
        end
        RNG_SAMPLE_CNT_OFS: rng_cpu_prdata[15:0] = sample_cnt_q;
        default: begin
          if (ehr_hit && ehr_valid) begin
            rng_cpu_prdata = ehr[{ehr_ofs[7:2], 5'b00000} +: 32];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rng_ehr_regs.sv
module tb_rng_ehr_regs;
  import rng_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0;
  logic        pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        rnd_bit;
  logic        rosc_en;
  logic        rng_irq;

  // rnd_bit source: fixed value, or alternating 1,0,... per collect cycle
  logic fixed_bit = 1'b1;
  logic pat = 1'b0;
  logic pat_bit = 1'b1;
  logic alt = 1'b1;
  assign rnd_bit = pat ? pat_bit : fixed_bit;

  always #5 clk = ~clk;

  rng_ehr_regs dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_rng_psel   (psel),
    .cpu_rng_pwrite (pwrite),
    .cpu_rng_paddr  (paddr),
    .cpu_rng_pwdata (pwdata),
    .rng_cpu_prdata (prdata),
    .rnd_bit_in     (rnd_bit),
    .rosc_en        (rosc_en),
    .rng_irq        (rng_irq)
  );

  always @(negedge clk) begin
    if (!pat) begin
      alt = 1'b1;
    end else if (rosc_en) begin
      pat_bit = alt;
      alt = ~alt;
    end
  end

  // Scoreboard: sel 0 = prdata, 1 = rosc_en, 2 = rng_irq
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        cur;
  logic [31:0] act;
  logic        mon_req = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  always @(negedge clk) begin
    if (mon_req) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty: got output with no expected entry");
      end else begin
        cur = sb_q.pop_front();
        case (cur.sel)
          0:       act = prdata;
          1:       act = {31'b0, rosc_en};
          default: act = {31'b0, rng_irq};
        endcase
        if (act !== cur.exp) begin
          n_err++;
          $display("FAIL %s: got %08h expected %08h", cur.name, act, cur.exp);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_sig(input string nm, input int sel, input logic [31:0] v);
    sb_q.push_back('{nm, sel, v});
    mon_req = 1'b1;
    @(negedge clk);
    #1;
    mon_req = 1'b0;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    tick();
    psel = 1'b1; paddr = {4'h0, a}; pwrite = 1'b0; pwdata = d;
    tick();
    pwrite = 1'b1;
    tick();
    psel = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input string nm, input logic [11:0] a, input logic [31:0] e);
    tick();
    psel = 1'b1; paddr = a; pwrite = 1'b0;
    tick();
    sb_q.push_back('{nm, 0, e});
    mon_req = 1'b1;
    tick();
    mon_req = 1'b0; psel = 1'b0;
  endtask

  // Two reads with psel held high across both transfers.
  task automatic apb_read2(input logic [7:0] a, input logic [31:0] e1, input logic [31:0] e2);
    tick();
    psel = 1'b1; paddr = {4'h0, a}; pwrite = 1'b0;
    tick();
    sb_q.push_back('{"b2b_first", 0, e1});
    mon_req = 1'b1;
    tick();
    mon_req = 1'b0;
    tick();
    sb_q.push_back('{"b2b_second", 0, e2});
    mon_req = 1'b1;
    tick();
    mon_req = 1'b0; psel = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ---------------- Reset values ----------------
    do_reset();
    expect_sig("rst_rosc_en", 1, 32'd0);
    expect_sig("rst_rng_irq", 2, 32'd0);
    apb_read("rst_ctrl",   12'h000, 32'h0);
    apb_read("rst_status", 12'h004, 32'h0);
    apb_read("rst_smpcnt", 12'h008, 32'h64);
    apb_read("rst_icr",    12'h00C, 32'h0);
    for (int k = 0; k < 6; k++) begin
      apb_read("rst_ehr", 12'(16 + 4 * k), 32'h0);
    end
    apb_read("rst_unmapped", 12'h028, 32'h0);
    apb_read("rst_hi_addr_smpcnt", 12'h508, 32'h64);

    // ---------------- Fill with ones, SAMPLE_CNT=2 ----------------
    fixed_bit = 1'b1;
    apb_write(RNG_SAMPLE_CNT_OFS, 32'h0000_0002);
    apb_read("fill_smpcnt", 12'h008, 32'h2);
    apb_write(RNG_CTRL_OFS, 32'h3);
    tick();
    expect_sig("fill_rosc_en_on", 1, 32'd1);
    tick(573);
    apb_read("fill_busy_before_full", 12'h004, 32'h2);
    expect_sig("fill_irq_lag", 2, 32'd0);
    tick();
    expect_sig("fill_irq_set", 2, 32'd1);
    expect_sig("fill_rosc_en_off", 1, 32'd0);
    apb_read("fill_status", 12'h004, 32'h5);
    apb_read("fill_ctrl",   12'h000, 32'h3);
    for (int k = 0; k < 5; k++) begin
      apb_read("fill_ehr", 12'(16 + 4 * k), 32'hFFFF_FFFF);
    end

    // ---------------- ICR clear while FULL ----------------
    apb_write(RNG_ICR_OFS, 32'h1);
    expect_sig("icr_irq_still_high", 2, 32'd1);
    tick();
    expect_sig("icr_irq_low", 2, 32'd0);
    apb_read("icr_status", 12'h004, 32'h1);
    apb_write(RNG_STATUS_OFS, 32'hFFFF_FFFF);
    apb_write(RNG_EHR0_OFS, 32'h0);
    apb_read("ro_status_unchanged", 12'h004, 32'h1);
    apb_read("ro_ehr0_unchanged",   12'h010, 32'hFFFF_FFFF);
    apb_read("icr_reads_zero",      12'h00C, 32'h0);

    // ---------------- Back-to-back EHR_DATA5 reads ----------------
    apb_read2(RNG_EHR5_OFS, 32'hFFFF_FFFF, 32'h0);
    apb_read("b2b_status_restart", 12'h004, 32'h2);
    expect_sig("b2b_rosc_en", 1, 32'd1);
    apb_read("b2b_ehr0_invalid", 12'h010, 32'h0);

    // ---------------- Alternating pattern, SAMPLE_CNT=0 ----------------
    do_reset();
    apb_write(RNG_SAMPLE_CNT_OFS, 32'h0);
    pat = 1'b1;
    apb_write(RNG_CTRL_OFS, 32'h1);
    tick(200);
    pat = 1'b0;
    for (int k = 0; k < 6; k++) begin
      apb_read("pat_ehr", 12'(16 + 4 * k), 32'hAAAA_AAAA);
    end
    apb_read("pat_status_after_consume", 12'h004, 32'h6);
    expect_sig("pat_irq_masked", 2, 32'd0);

    // ---------------- Abort and re-enable ----------------
    do_reset();
    apb_write(RNG_SAMPLE_CNT_OFS, 32'h0);
    fixed_bit = 1'b0;
    apb_write(RNG_CTRL_OFS, 32'h1);
    tick(49);
    apb_write(RNG_CTRL_OFS, 32'h0);
    tick();
    expect_sig("abort_rosc_en", 1, 32'd0);
    apb_read("abort_status", 12'h004, 32'h0);
    fixed_bit = 1'b1;
    apb_write(RNG_CTRL_OFS, 32'h1);
    tick(190);
    apb_read("reen_busy_at_191", 12'h004, 32'h2);
    apb_read("reen_status_full", 12'h004, 32'h5);
    apb_read("reen_ehr0", 12'h010, 32'hFFFF_FFFF);
    expect_sig("reen_irq_masked", 2, 32'd0);

    tick(2);
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
